// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sequences a vector stream through an external 8-bit FP/int adder and returns the sum
module fp_accum_seq #(
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             mode,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_mode,
    input  logic [7:0]       add_res,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           state;
    logic [7:0]       acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             mode_q;
    // adder operands: idle elements feed zero so the adder input is quiet between handshakes
    always_comb begin
        in_ready = state == ACC;
        busy     = state != IDLE;
        add_a    = acc;
        add_b    = (state == ACC && in_valid) ? in_data : 8'h00;
        add_mode = mode_q;
    end
    // run control: launch, accumulate one element per handshake, hold result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 8'h00;
            cnt       <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (vec_len != '0) begin
                        state  <= ACC;
                        len_q  <= vec_len;
                        mode_q <= mode;
                        acc    <= 8'h00;
                        cnt    <= '0;
                    end else begin
                        state     <= DONE;
                        out_data  <= 8'h00;
                        out_valid <= 1'b1;
                    end
                end
                ACC: if (in_valid) begin
                    acc <= add_res;
                    if (cnt == len_q - LEN_W'(1)) begin
                        out_data  <= add_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: randomized self-checking bench with a value-level adder model and fold reference
module tb_fp_accum_seq;
    localparam int LEN_W = 6;
    logic             clk = 1'b0;
    logic             rst, start, mode, in_valid, out_ready;
    logic [LEN_W-1:0] vec_len;
    logic [7:0]       in_data, add_a, add_b, add_res, out_data;
    logic             in_ready, add_mode, out_valid, busy;
    int               n_cmp = 0;
    int               n_err = 0;
    logic [7:0]       elems[$];
    int               gaps[$];

    fp_accum_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_mode(add_mode), .add_res(add_res),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // FP value in units of 2^-7: (1.mmmm) * 2^(e-3)
    function automatic int fp_val(input logic [7:0] x);
        int mag;
        if (x == 8'h00) return 0;
        mag = (16 + int'(x[3:0])) << x[6:4];
        return x[7] ? -mag : mag;
    endfunction

    // truncating encode: tiny magnitudes flush to zero, large ones saturate
    function automatic logic [7:0] fp_enc(input int v);
        int mag;
        logic s;
        if (v == 0) return 8'h00;
        s = v < 0;
        mag = s ? -v : v;
        if (mag < 16) return 8'h00;
        if (mag >= (32 << 7)) return {s, 3'd7, 4'hF};
        for (int e = 0; e < 8; e++)
            if ((mag >> e) < 32) return {s, 3'(e), 4'((mag >> e) - 16)};
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic m);
        return m ? 8'(int'(a) + int'(b)) : fp_enc(fp_val(a) + fp_val(b));
    endfunction

    assign add_res = ref_add(add_a, add_b, add_mode);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one complete run over elems/gaps, then a stalled result drain with stray starts
    task automatic run(input logic m, input int stall);
        logic [7:0] acc_m;
        int n;
        acc_m = 8'h00;
        n = elems.size();
        start = 1'b1; vec_len = LEN_W'(n); mode = m;
        tick();
        start = 1'b0; vec_len = LEN_W'($urandom); mode = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                #1;
                chk("gap_hold_a", 32'(add_a), 32'(acc_m));
                chk("gap_b_zero", 32'(add_b), 32'h0);
                chk("gap_ready", 32'(in_ready), 32'h1);
                tick();
            end
            in_valid = 1'b1; in_data = elems[i];
            #1;
            chk("acc_ready", 32'(in_ready), 32'h1);
            chk("add_a", 32'(add_a), 32'(acc_m));
            chk("add_b", 32'(add_b), 32'(elems[i]));
            chk("add_mode", 32'(add_mode), 32'(m));
            tick();
            acc_m = ref_add(acc_m, elems[i], m);
            in_valid = 1'b0;
        end
        #1;
        chk("done_valid", 32'(out_valid), 32'h1);
        chk("done_data", 32'(out_data), 32'(acc_m));
        chk("done_ready", 32'(in_ready), 32'h0);
        chk("done_busy", 32'(busy), 32'h1);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0; start = 1'($urandom); vec_len = LEN_W'($urandom);
            tick();
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_data", 32'(out_data), 32'(acc_m));
        end
        out_ready = 1'b1; start = 1'b1; vec_len = LEN_W'(1);
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_busy", 32'(busy), 32'h0);
        tick();
        chk("late_start_ignored", 32'(busy), 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; vec_len = LEN_W'(3); mode = 1'b1;
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_add_a", 32'(add_a), 32'h0);
        chk("rst_mode", 32'(add_mode), 32'h0);
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        elems = '{8'h01, 8'h02, 8'h03}; gaps = '{0, 0, 0};
        run(1'b1, 0);
        elems = '{8'hF0, 8'h20}; gaps = '{0, 2};
        run(1'b1, 1);
        elems = {}; gaps = {};
        run(1'b0, 0);
        elems = '{8'h30, 8'h30}; gaps = '{0, 0};
        run(1'b0, 5);

        start = 1'b1; vec_len = LEN_W'(4); mode = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom_range(1, 255));
            tick();
        end
        rst = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(in_ready), 32'h0);
        chk("abort_valid", 32'(out_valid), 32'h0);
        chk("abort_acc", 32'(add_a), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_pulse", 32'(out_valid), 32'h0);
        end
        elems = '{8'h07}; gaps = '{0};
        run(1'b1, 0);

        elems = {}; gaps = {};
        for (int i = 0; i < (1 << LEN_W) - 1; i++) begin
            elems.push_back(8'($urandom));
            gaps.push_back(0);
        end
        run(1'($urandom), 2);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 10);
            elems = {}; gaps = {};
            for (int i = 0; i < n; i++) begin
                elems.push_back(8'($urandom));
                gaps.push_back($urandom_range(0, 2));
            end
            run(1'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp_accum_seq.md
FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 Parameter: LEN_W, default 6, width of vector-length field and element counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request new accumulation; sampled only in IDLE.
REQ-005 Port: vec_len  input  LEN_W  element count for the run; sampled with start.
REQ-006 Port: mode  input  1  0 = 8-bit FP add, 1 = 8-bit integer add; sampled with start.
REQ-007 Port: in_data  input  8  stream element; FP format [7] sign, [6:4] exp, [3:0] mantissa; 8'h00 is zero.
REQ-008 Port: in_valid  input  1  in_data valid.
REQ-009 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-010 Port: add_a  output  8  operand A to the downstream combinational adder (accumulator).
REQ-011 Port: add_b  output  8  operand B to the adder (current element).
REQ-012 Port: add_mode  output  1  mode to the adder (latched mode).
REQ-013 Port: add_res  input  8  adder result, combinational function of add_a/add_b/add_mode.
REQ-014 Port: out_data  output  8  final accumulated value.
REQ-015 Port: out_valid  output  1  out_data valid.
REQ-016 Port: out_ready  input  1  consumer accepts out_data.
REQ-017 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACC, DONE.
REQ-019 IDLE: start=1, vec_len!=0 -> ACC; latch vec_len and mode, acc <= 8'h00, cnt <= 0.
REQ-020 IDLE: start=1, vec_len==0 -> DONE with out_data <= 8'h00, no element consumed.
REQ-021 in_ready SHALL be 1 only in ACC; 0 in IDLE and DONE.
REQ-022 add_a SHALL equal acc; add_b SHALL equal in_data when in ACC and in_valid=1, else 8'h00; add_mode SHALL equal latched mode.
REQ-023 ACC handshake (in_valid & in_ready): acc <= add_res, cnt <= cnt+1; no handshake -> acc, cnt hold.
REQ-024 ACC handshake with cnt == latched_len-1: out_data <= add_res, out_valid <= 1, -> DONE; result visible the cycle after final element (latency 1).
REQ-025 DONE: out_valid=1, out_data stable until out_valid & out_ready; then out_valid <= 0, -> IDLE.
REQ-026 start SHALL be ignored in ACC and DONE, including a start coincident with the DONE->IDLE transition; a new run needs start in IDLE.
REQ-027 Changes on vec_len/mode SHALL not affect a run in progress.
REQ-028 cnt SHALL never exceed latched_len-1; no wrap; vec_len = 2^LEN_W-1 SHALL be supported.
REQ-029 Integer mode SHALL rely on adder modulo-256 wrap; block adds no saturation or zero forcing.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, acc=8'h00, cnt=0, out_data=8'h00, out_valid=0, in_ready=0, busy=0, latched mode=0, latched_len=0, regardless of current state.
REQ-031 Reset mid-run SHALL discard partial sum; no out_valid pulse for the aborted run.
REQ-032 rst has priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-033 Bench SHALL model the adder: mode 1 = (a+b) mod 256; mode 0 = reference FP model; outputs zero when both operands 8'h00.
REQ-034 Scenario: mode=1, vec_len=3, elements 0x01,0x02,0x03 back-to-back -> add_a sequence 0x00,0x01,0x03; out_valid one cycle after 3rd handshake, out_data=0x06.
REQ-035 Scenario: mode=1, vec_len=2, elements 0xF0,0x20 with in_valid gap of 2 cycles between them -> acc holds 0xF0 during gap; out_data=0x10 (wrap).
REQ-036 Scenario: start with vec_len=0 -> in_ready stays 0, out_valid=1 next cycle, out_data=0x00; out_ready=1 -> IDLE, busy=0.
REQ-037 Scenario: mode=0, vec_len=2, elements 0x30,0x30 -> add_b sequence 0x30,0x30, add_mode=0, out_data equals model result; hold out_ready=0 for 5 cycles -> out_data/out_valid stable; start pulses in that window ignored.
REQ-038 Scenario: rst asserted after 2 of 4 elements (mode=1) -> next cycle busy=0, in_ready=0, out_valid=0; fresh run vec_len=1, element 0x07 -> out_data=0x07.
